mult_div: RTL and testbench
===========================

MULT_DIV -- requirements
Module: mult_div

Interface
REQ-001 Parameter ITER_COUNT, default 32: number of radix-2 iteration cycles per operation.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  launch request; sampled only when busy=0.
REQ-005 op  input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
REQ-006 operand0  input  32  multiplicand / dividend.
REQ-007 operand1  input  32  multiplier / divisor.
REQ-008 hi_we  input  1  MTHI write strobe.
REQ-009 lo_we  input  1  MTLO write strobe.
REQ-010 wdata  input  32  data for hi_we/lo_we.
REQ-011 busy  output  1  operation in progress.
REQ-012 done  output  1  one-cycle pulse: hi/lo just updated by an operation.
REQ-013 div_by_zero  output  1  last completed divide had operand1=0; held until next accepted start.
REQ-014 hi  output  32  HI register (product[63:32] / remainder).
REQ-015 lo  output  32  LO register (product[31:0] / quotient).

Function
REQ-016 States: IDLE, RUN, FINISH; IDLE->RUN on start at edge E0; RUN->FINISH after ITER_COUNT iteration edges (E1..E32); FINISH->IDLE at E33.
REQ-017 At E0: latch op, absolute values of operands (signed ops only), result-sign flags; clear div_by_zero; load iteration counter.
REQ-018 busy=1 from the cycle after E0 through the cycle ending at E33; busy=0 otherwise.
REQ-019 At E33: sign-correct, write hi/lo, done=1 for exactly the following cycle.
REQ-020 Latency: done high exactly 34 cycles after the start-sampling cycle; back-to-back start accepted in the done cycle.
REQ-021 Multiply: shift-add on unsigned magnitudes, 64-bit result; signed result negated when operand signs differ.
REQ-022 Divide: restoring shift-subtract; quotient sign = sign0 XOR sign1; remainder sign = dividend sign.
REQ-023 DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0, no flag.
REQ-024 Divisor 0: skip RUN; go to FINISH at E1; hi=operand0, lo=0xFFFFFFFF, div_by_zero=1, done pulse the cycle after E1.
REQ-025 hi/lo hold previous values during RUN/FINISH until E33; working registers are separate.
REQ-026 hi_we/lo_we honoured only when busy=0 and start=0; ignored otherwise (start has priority).
REQ-027 start while busy=1 ignored, no queueing; op/operand changes while busy have no effect.

Reset
REQ-028 rst_n=0 at a clock edge: state IDLE, busy=0, done=0, div_by_zero=0, hi=0, lo=0, counter=0.
REQ-029 Reset mid-operation aborts it; no done pulse; hi/lo cleared to 0.
REQ-030 start asserted in the same cycle as rst_n=0 is discarded.

Structure
REQ-031 Package mult_div_pkg holds op encodings, FSM state typedef, ITER_COUNT default.
REQ-032 One sub-module mult_div_datapath: shift/add/subtract registers and sign correction; FSM and counter in mult_div.
REQ-033 Counter width = clog2(ITER_COUNT)+1.

Verification
REQ-034 MULT -3 x 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1, done at cycle 34.
REQ-035 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-036 DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 0x80000000 / -1 -> lo=0x80000000, hi=0.
REQ-037 DIVU 100 / 0 -> div_by_zero=1, hi=100, lo=0xFFFFFFFF, done 2 cycles after start.
REQ-038 start + hi_we during busy -> ignored; hi/lo unchanged until done; result matches first op only.
REQ-039 rst_n=0 at cycle 10 of MULT -> busy=0, hi=lo=0, no done pulse; new start next cycle completes normally.

Source files
------------

// File: rtl/mult_div_pkg.sv
// Shared encodings and helpers for the iterative multiply/divide unit.
package mult_div_pkg;

  localparam int ITER_COUNT_DEFAULT = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/mult_div_datapath.sv
// Working registers for radix-2 shift-add multiply and restoring divide,
// plus the final sign correction of the 64-bit result.
module mult_div_datapath
  import mult_div_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic        step_i,
  input  logic        div_zero_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] operand0_i,
  input  logic [31:0] operand1_i,
  output logic        div_zero_o,
  output logic [31:0] res_hi_o,
  output logic [31:0] res_lo_o
);

  logic        is_div_q, is_div_d;
  logic        div_zero_q, div_zero_d;
  logic        res_neg_q, res_neg_d;
  logic        rem_neg_q, rem_neg_d;
  logic [31:0] mag_q, mag_d;
  logic [63:0] acc_q, acc_d;

  logic        signed_op;
  logic        sign0, sign1;
  logic [31:0] mag0, mag1;
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] rem_sh;
  logic        div_ge;
  logic [31:0] div_rem;
  logic [63:0] div_next;
  logic [63:0] prod_fix;

  assign signed_op = ~op_i[0];
  assign sign0     = signed_op & operand0_i[31];
  assign sign1     = signed_op & operand1_i[31];
  assign mag0      = signed_op ? abs32(operand0_i) : operand0_i;
  assign mag1      = signed_op ? abs32(operand1_i) : operand1_i;

  // Multiply: multiplier sits in acc[31:0] and is consumed from bit 0 while
  // partial sums enter from the top with their carry.
  assign mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mag_q} : 33'd0);
  assign mul_next = {mul_sum, acc_q[31:1]};

  // Divide: acc = {remainder, dividend bits shifting into remainder / quotient bits}.
  assign rem_sh   = {acc_q[63:32], acc_q[31]};
  assign div_ge   = (rem_sh >= {1'b0, mag_q});
  assign div_rem  = rem_sh[31:0] - mag_q;
  assign div_next = div_ge ? {div_rem, acc_q[30:0], 1'b1}
                           : {rem_sh[31:0], acc_q[30:0], 1'b0};

  always_comb begin
    is_div_d   = is_div_q;
    div_zero_d = div_zero_q;
    res_neg_d  = res_neg_q;
    rem_neg_d  = rem_neg_q;
    mag_d      = mag_q;
    acc_d      = acc_q;
    if (load_i) begin
      is_div_d   = op_i[1];
      div_zero_d = div_zero_i;
      res_neg_d  = ~div_zero_i & (sign0 ^ sign1);
      rem_neg_d  = ~div_zero_i & sign0;
      mag_d      = op_i[1] ? mag1 : mag0;
      // A zero divisor keeps the raw dividend so it can be returned in hi.
      if (div_zero_i)    acc_d = {32'd0, operand0_i};
      else if (op_i[1])  acc_d = {32'd0, mag0};
      else               acc_d = {32'd0, mag1};
    end else if (step_i) begin
      acc_d = is_div_q ? div_next : mul_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      is_div_q   <= 1'b0;
      div_zero_q <= 1'b0;
      res_neg_q  <= 1'b0;
      rem_neg_q  <= 1'b0;
      mag_q      <= '0;
      acc_q      <= '0;
    end else begin
      is_div_q   <= is_div_d;
      div_zero_q <= div_zero_d;
      res_neg_q  <= res_neg_d;
      rem_neg_q  <= rem_neg_d;
      mag_q      <= mag_d;
      acc_q      <= acc_d;
    end
  end

  assign prod_fix = res_neg_q ? (64'd0 - acc_q) : acc_q;

  always_comb begin
    res_hi_o = prod_fix[63:32];
    res_lo_o = prod_fix[31:0];
    if (div_zero_q) begin
      res_hi_o = acc_q[31:0];
      res_lo_o = 32'hFFFF_FFFF;
    end else if (is_div_q) begin
      res_hi_o = rem_neg_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
      res_lo_o = res_neg_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
    end
  end

  assign div_zero_o = div_zero_q;

endmodule

// File: rtl/mult_div.sv
// Iterative multiply/divide unit with HI/LO result registers: control FSM,
// iteration counter and architectural registers around the datapath.
module mult_div
  import mult_div_pkg::*;
#(
  parameter int ITER_COUNT = ITER_COUNT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] operand0,
  input  logic [31:0] operand1,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CNT_W = $clog2(ITER_COUNT) + 1;

  state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;
  logic        dbz_q, dbz_d;

  logic        load;
  logic        step;
  logic        start_div_zero;
  logic        dp_div_zero;
  logic [31:0] res_hi;
  logic [31:0] res_lo;

  assign start_div_zero = op[1] && (operand1 == 32'd0);

  mult_div_datapath u_datapath (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (load),
    .step_i     (step),
    .div_zero_i (start_div_zero),
    .op_i       (op),
    .operand0_i (operand0),
    .operand1_i (operand1),
    .div_zero_o (dp_div_zero),
    .res_hi_o   (res_hi),
    .res_lo_o   (res_lo)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dbz_d   = dbz_q;
    done_d  = 1'b0;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // start outranks the MTHI/MTLO strobes in the same cycle.
        if (start) begin
          load    = 1'b1;
          cnt_d   = CNT_W'(ITER_COUNT);
          dbz_d   = 1'b0;
          state_d = start_div_zero ? ST_FINISH : ST_RUN;
        end else begin
          if (hi_we) hi_d = wdata;
          if (lo_we) lo_d = wdata;
        end
      end
      ST_RUN: begin
        step  = 1'b1;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = ST_FINISH;
      end
      ST_FINISH: begin
        hi_d    = res_hi;
        lo_d    = res_lo;
        dbz_d   = dp_div_zero;
        done_d  = 1'b1;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_mult_div.sv
// Self-checking bench for mult_div: directed vector table, hand-written
// sequences for reset/priority corners, and random ops against an arithmetic model.
module tb_mult_div;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] operand0;
  logic [31:0] operand1;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  mult_div dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .op          (op),
    .operand0    (operand0),
    .operand1    (operand1),
    .hi_we       (hi_we),
    .lo_we       (lo_we),
    .wdata       (wdata),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic; SV '/' truncates and '%' follows the dividend sign.
  task automatic model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] mh, output logic [31:0] ml,
                       output logic mdz, output int mlat);
    longint      sa, sb, sp, sq, sr;
    logic [63:0] up;
    mdz  = 1'b0;
    mlat = 34;
    sa   = $signed(a);
    sb   = $signed(b);
    case (o)
      2'b00: begin sp = sa * sb; mh = sp[63:32]; ml = sp[31:0]; end
      2'b01: begin up = {32'd0, a} * {32'd0, b}; mh = up[63:32]; ml = up[31:0]; end
      default: begin
        if (b == 32'd0) begin
          mh = a; ml = 32'hFFFF_FFFF; mdz = 1'b1; mlat = 2;
        end else if (o == 2'b10) begin
          sq = sa / sb; sr = sa % sb; mh = sr[31:0]; ml = sq[31:0];
        end else begin
          mh = a % b; ml = a / b;
        end
      end
    endcase
  endtask

  // Launches one op (now=1: inputs are applied in the current cycle) and waits for done.
  task automatic run_op(input bit now, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, output logic [31:0] rh, output logic [31:0] rl,
                        output logic rdz, output int lat);
    logic [31:0] h0, l0;
    bit hold_ok;
    hold_ok = 1'b1;
    if (!now) @(negedge clk);
    op = o; operand0 = a; operand1 = b; start = 1'b1;
    h0 = hi; l0 = lo;
    @(negedge clk);
    start = 1'b0;
    op = 2'($urandom); operand0 = $urandom; operand1 = $urandom;
    lat = 1;
    chk("busy_cycle1", {31'd0, busy}, 32'd1);
    chk("dz_cleared_at_start", {31'd0, div_by_zero}, 32'd0);
    while (!done && lat < 100) begin
      if (hi !== h0 || lo !== l0) hold_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    chk("hilo_held_while_busy", {31'd0, hold_ok}, 32'd1);
    rh = hi; rl = lo; rdz = div_by_zero;
    $display("op=%0d a=%h b=%h -> hi=%h lo=%h dz=%0d lat=%0d", o, a, b, rh, rl, rdz, lat);
  endtask

  initial begin
    logic [31:0] rh, rl, mh, ml;
    logic        rdz, mdz;
    int          lat, mlat, cyc;
    bit          no_done;

    vecs[0]  = '{2'b00, 32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 34};
    vecs[1]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 34};
    vecs[2]  = '{2'b10, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34};
    vecs[3]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 34};
    vecs[4]  = '{2'b11, 32'd100,       32'd0,        32'd100,       32'hFFFF_FFFF, 1'b1, 2};
    vecs[5]  = '{2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0, 34};
    vecs[6]  = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 34};
    vecs[7]  = '{2'b11, 32'hFFFF_FFFF, 32'd3,        32'd0,         32'h5555_5555, 1'b0, 34};
    vecs[8]  = '{2'b10, 32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1, 2};
    vecs[9]  = '{2'b01, 32'd0,         32'h1234_5678, 32'd0,         32'd0,         1'b0, 34};
    vecs[10] = '{2'b10, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'd2,         1'b0, 34};

    // Reset with start asserted: the start must be discarded.
    rst_n = 1'b0; start = 1'b1; op = 2'b00; operand0 = 32'd3; operand1 = 32'd5;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    repeat (2) @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_dz", {31'd0, div_by_zero}, 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    rst_n = 1'b1; start = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", {31'd0, busy}, 32'd0);

    // MTHI / MTLO
    hi_we = 1'b1; wdata = 32'h1111_1111;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h2222_2222;
    @(negedge clk);
    lo_we = 1'b0;
    chk("mthi", hi, 32'h1111_1111);
    chk("mtlo", lo, 32'h2222_2222);

    // Directed table
    foreach (vecs[i]) begin
      run_op(1'b0, vecs[i].op, vecs[i].a, vecs[i].b, rh, rl, rdz, lat);
      chk($sformatf("vec%0d_hi", i), rh, vecs[i].hi);
      chk($sformatf("vec%0d_lo", i), rl, vecs[i].lo);
      chk($sformatf("vec%0d_dz", i), {31'd0, rdz}, {31'd0, vecs[i].dz});
      chk($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
    end

    // Back-to-back: new start in the done cycle of a divide-by-zero.
    run_op(1'b0, 2'b11, 32'd100, 32'd0, rh, rl, rdz, lat);
    run_op(1'b1, 2'b00, 32'hFFFF_FFFD, 32'd5, rh, rl, rdz, lat);
    chk("b2b_hi", rh, 32'hFFFF_FFFF);
    chk("b2b_lo", rl, 32'hFFFF_FFF1);
    chk("b2b_dz", {31'd0, rdz}, 32'd0);
    chk("b2b_lat", lat, 34);

    // start+hi_we together, then start+strobes while busy: all ignored but the first op.
    @(negedge clk);
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h3333_3333;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    op = 2'b01; operand0 = 32'd6; operand1 = 32'd7; start = 1'b1;
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0; cyc = 1;
    repeat (4) begin @(negedge clk); cyc++; end
    start = 1'b1; op = 2'b11; operand0 = 32'd100; operand1 = 32'd0;
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hCAFE_F00D;
    @(negedge clk); cyc++;
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    chk("busy_ignore_hi", hi, 32'h3333_3333);
    chk("busy_ignore_lo", lo, 32'h3333_3333);
    while (!done && cyc < 100) begin @(negedge clk); cyc++; end
    chk("ignore_lat", cyc, 34);
    chk("ignore_hi", hi, 32'd0);
    chk("ignore_lo", lo, 32'd42);
    chk("ignore_dz", {31'd0, div_by_zero}, 32'd0);
    no_done = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) no_done = 1'b0;
    end
    chk("no_queued_op", {31'd0, no_done}, 32'd1);

    // Reset at cycle 10 of a MULT aborts it.
    op = 2'b00; operand0 = 32'd1234; operand1 = 32'd5678; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    rst_n = 1'b1;
    run_op(1'b1, 2'b00, 32'd1234, 32'd5678, rh, rl, rdz, lat);
    chk("post_abort_lo", rl, 32'd7006652);
    chk("post_abort_hi", rh, 32'd0);
    chk("post_abort_lat", lat, 34);

    // Random operations against the model
    for (int n = 0; n < 40; n++) begin
      logic [1:0]  o;
      logic [31:0] a, b;
      o = 2'($urandom);
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: a = 32'h8000_0000;
        2: b = 32'hFFFF_FFFF;
        3: b = $urandom_range(1, 15);
        default: ;
      endcase
      model(o, a, b, mh, ml, mdz, mlat);
      run_op(1'b0, o, a, b, rh, rl, rdz, lat);
      chk($sformatf("rnd%0d_hi", n), rh, mh);
      chk($sformatf("rnd%0d_lo", n), rl, ml);
      chk($sformatf("rnd%0d_dz", n), {31'd0, rdz}, {31'd0, mdz});
      chk($sformatf("rnd%0d_lat", n), lat, mlat);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
